robo_arena: RTL

ROBO_ARENA -- requirements
Module: robo_arena

---
 rtl/robo_arena_pkg.sv | 36 +++
 rtl/arena_neighbor.sv | 48 ++++
 rtl/robo_arena.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/robo_arena_pkg.sv
// robo_arena_pkg: shared encodings for the robot arena.
// Heading encoding, grid geometry, one-hot command encoding and cell indexing.
package robo_arena_pkg;

  localparam int GRID_SIZE = 8;
  localparam logic [2:0] GRID_MAX = 3'(GRID_SIZE - 1);

  // Headings step clockwise: N(y+1), E(x+1), S(y-1), W(x-1).
  typedef enum logic [1:0] {
    HEAD_N = 2'd0,
    HEAD_E = 2'd1,
    HEAD_S = 2'd2,
    HEAD_W = 2'd3
  } heading_t;

  // Command bits as {remove, turn, forward}; anything else is idle or illegal.
  typedef enum logic [2:0] {
    CMD_NONE    = 3'b000,
    CMD_FORWARD = 3'b001,
    CMD_TURN    = 3'b010,
    CMD_REMOVE  = 3'b100
  } cmd_t;

  // One neighbouring cell: coordinates plus a flag for stepping off the grid.
  typedef struct packed {
    logic       out;
    logic [2:0] x;
    logic [2:0] y;
  } cell_t;

  // Bit position of cell (x,y) in the 64-bit wall and debris maps.
  function automatic logic [5:0] cell_index(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/arena_neighbor.sv
// arena_neighbor: combinational lookup of the cell ahead of the robot and
// the cell to its left (90 degrees counter-clockwise), with off-grid flags.
module arena_neighbor
  import robo_arena_pkg::*;
(
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  input  logic [1:0] heading,
  output logic [2:0] ahead_x,
  output logic [2:0] ahead_y,
  output logic       ahead_out,
  output logic [2:0] left_x,
  output logic [2:0] left_y,
  output logic       left_out
);

  cell_t ahead_cell;
  cell_t left_cell;

  // One step from (x,y) along dir; out is set when the step leaves the grid,
  // in which case the wrapped coordinates are meaningless.
  function automatic cell_t step_cell(input logic [2:0] x, input logic [2:0] y,
                                      input logic [1:0] dir);
    cell_t c;
    c.x   = x;
    c.y   = y;
    c.out = 1'b0;
    case (heading_t'(dir))
      HEAD_N: begin c.y = y + 3'd1; c.out = (y == GRID_MAX); end
      HEAD_E: begin c.x = x + 3'd1; c.out = (x == GRID_MAX); end
      HEAD_S: begin c.y = y - 3'd1; c.out = (y == 3'd0);     end
      default: begin c.x = x - 3'd1; c.out = (x == 3'd0);    end
    endcase
    return c;
  endfunction

  // Counter-clockwise neighbour is heading-1 modulo 4.
  assign ahead_cell = step_cell(pos_x, pos_y, heading);
  assign left_cell  = step_cell(pos_x, pos_y, heading - 2'd1);

  assign ahead_x   = ahead_cell.x;
  assign ahead_y   = ahead_cell.y;
  assign ahead_out = ahead_cell.out;
  assign left_x    = left_cell.x;
  assign left_y    = left_cell.y;
  assign left_out  = left_cell.out;

endmodule

// File: rtl/robo_arena.sv
// robo_arena: 8x8 grid robot with held-command action timer, registered
// sensors and a debris map. Define ROBO_ARENA_COLLISION_CNT_EN to build the
// blocked-move counter; otherwise collisions reads as zero.
module robo_arena
  import robo_arena_pkg::*;
#(
  parameter int          ACT_CYCLES  = 4,
  parameter logic [63:0] WALL_MAP    = 64'h0,
  parameter logic [63:0] DEBRIS_INIT = 64'h0,
  parameter int          START_X     = 0,
  parameter int          START_Y     = 0,
  parameter int          START_DIR   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       forward,
  input  logic       turn,
  input  logic       remove,
  output logic       head,
  output logic       left,
  output logic       under,
  output logic       barrier,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic [1:0] heading,
  output logic [6:0] debris_left,
  output logic [7:0] collisions,
  output logic       cmd_err,
  output logic       done
);

  localparam logic [3:0] ACT_LAST     = 4'(ACT_CYCLES - 1);
  localparam logic [2:0] HOME_X       = 3'(START_X);
  localparam logic [2:0] HOME_Y       = 3'(START_Y);
  localparam logic [1:0] HOME_DIR     = 2'(START_DIR);
  localparam logic [6:0] DEBRIS_COUNT = 7'($countones(DEBRIS_INIT));

  logic [2:0]  pos_x_reg;
  logic [2:0]  pos_y_reg;
  logic [1:0]  heading_reg;
  logic [63:0] debris_reg;
  logic [6:0]  debris_left_reg;
  logic        cmd_err_reg;
  logic [3:0]  timer_reg;
  logic [2:0]  prev_cmd_reg;
  logic        head_reg;
  logic        left_reg;
  logic        under_reg;
  logic        barrier_reg;

  logic [2:0] ahead_x;
  logic [2:0] ahead_y;
  logic       ahead_out;
  logic [2:0] left_x;
  logic [2:0] left_y;
  logic       left_out;
  logic [5:0] ahead_idx;
  logic [5:0] left_idx;
  logic       ahead_wall;
  logic       ahead_debris;
  logic       left_wall;
  logic       at_home;

  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_multi;
  logic [3:0] timer_eff;
  logic       fire;

  arena_neighbor u_neighbor (
    .pos_x     (pos_x_reg),
    .pos_y     (pos_y_reg),
    .heading   (heading_reg),
    .ahead_x   (ahead_x),
    .ahead_y   (ahead_y),
    .ahead_out (ahead_out),
    .left_x    (left_x),
    .left_y    (left_y),
    .left_out  (left_out)
  );

  // Off-grid cells behave as walls and never hold debris.
  assign ahead_idx    = cell_index(ahead_x, ahead_y);
  assign left_idx     = cell_index(left_x, left_y);
  assign ahead_wall   = ahead_out || WALL_MAP[ahead_idx];
  assign left_wall    = left_out || WALL_MAP[left_idx];
  assign ahead_debris = !ahead_out && debris_reg[ahead_idx];
  assign at_home      = (pos_x_reg == HOME_X) && (pos_y_reg == HOME_Y);

  // A new command restarts the count at zero; the action fires on the cycle
  // the running count reaches ACT_CYCLES-1.
  assign cmd       = {remove, turn, forward};
  assign cmd_valid = (cmd == CMD_FORWARD) || (cmd == CMD_TURN) || (cmd == CMD_REMOVE);
  assign cmd_multi = (cmd != CMD_NONE) && !cmd_valid;
  assign timer_eff = (cmd == prev_cmd_reg) ? timer_reg : 4'd0;
  assign fire      = cmd_valid && (timer_eff == ACT_LAST);

  // Pose, debris map, command timer, error flag and registered sensors.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x_reg       <= HOME_X;
      pos_y_reg       <= HOME_Y;
      heading_reg     <= HOME_DIR;
      debris_reg      <= DEBRIS_INIT;
      debris_left_reg <= DEBRIS_COUNT;
      cmd_err_reg     <= 1'b0;
      timer_reg       <= 4'd0;
      prev_cmd_reg    <= CMD_NONE;
      head_reg        <= 1'b0;
      left_reg        <= 1'b0;
      under_reg       <= 1'b0;
      barrier_reg     <= 1'b0;
    end else begin
      head_reg    <= ahead_wall;
      left_reg    <= left_wall;
      under_reg   <= at_home;
      barrier_reg <= ahead_debris;

      if (cmd_multi) begin
        cmd_err_reg <= 1'b1;
      end

      if (cmd_valid) begin
        prev_cmd_reg <= cmd;
        timer_reg    <= fire ? 4'd0 : timer_eff + 4'd1;
      end else begin
        prev_cmd_reg <= CMD_NONE;
        timer_reg    <= 4'd0;
      end

      if (fire) begin
        case (cmd)
          CMD_TURN: heading_reg <= heading_reg + 2'd1;
          CMD_FORWARD: begin
            if (!ahead_wall && !ahead_debris) begin
              pos_x_reg <= ahead_x;
              pos_y_reg <= ahead_y;
            end
          end
          CMD_REMOVE: begin
            if (ahead_debris) begin
              debris_reg[ahead_idx] <= 1'b0;
              debris_left_reg       <= debris_left_reg - 7'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ROBO_ARENA_COLLISION_CNT_EN
  logic [7:0] collisions_reg;
  logic       blocked_move;

  assign blocked_move = fire && (cmd == CMD_FORWARD) && (ahead_wall || ahead_debris);

  // Saturating count of forward actions that could not move.
  always_ff @(posedge clock) begin
    if (reset) begin
      collisions_reg <= 8'd0;
    end else if (blocked_move && (collisions_reg != 8'hFF)) begin
      collisions_reg <= collisions_reg + 8'd1;
    end
  end

  assign collisions = collisions_reg;
`else
  assign collisions = 8'd0;
`endif

  assign pos_x       = pos_x_reg;
  assign pos_y       = pos_y_reg;
  assign heading     = heading_reg;
  assign debris_left = debris_left_reg;
  assign cmd_err     = cmd_err_reg;
  assign done        = (debris_left_reg == 7'd0);
  assign head        = head_reg;
  assign left        = left_reg;
  assign under       = under_reg;
  assign barrier     = barrier_reg;

endmodule
